jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Shares one bank of N JK flip-flops between two command requesters.
- Each requester issues a command (HOLD/SET/CLEAR/TOGGLE) with a bit mask.
- The block arbitrates between requesters round-robin, converts the command into per-bit J/K drives, and sequences one bank update per accepted command.
- Sits between control logic and the JK register bank; the bank is the only state it modifies.

Parameters:
- N, 8, width of the JK bank and of each command mask.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clk.
- req0_valid  input  1  requester 0 has a command.
- req0_op  input  2  requester 0 opcode: 00 HOLD, 01 SET, 10 CLEAR, 11 TOGGLE.
- req0_mask  input  N  requester 0 bit select.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req1_valid  input  1  requester 1 has a command.
- req1_op  input  2  requester 1 opcode, same encoding.
- req1_mask  input  N  requester 1 bit select.
- req1_ready  output  1  requester 1 command accepted this cycle.
- q  output  N  JK bank state.
- busy  output  1  a command is in flight (state != IDLE).
- grant_id  output  1  requester of the current/last accepted command.
- done  output  1  one-cycle pulse when the bank update is visible on q.

Behaviour:
- Reset (reset==0 at posedge): clk and reset are the only clock/reset; reset is synchronous and active-low.
  - Values after reset: q=0, state=IDLE, busy=0, done=0, grant_id=0, last_grant=1 (so req0 wins the first contention).
  - req*_ready=0 while reset is low.
  - Reset overrides every other event in the same cycle.
- Handshake:
  - valid/ready. A requester holds valid, op and mask stable until it sees ready.
  - Transfer occurs on the posedge where valid&&ready.
  - ready is combinational and is asserted only in IDLE, only for the winner. At most one ready is high per cycle.
- Arbitration, IDLE only:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - On transfer: last_grant and grant_id take the winner id; op and mask are latched.
- FSM:
  - IDLE: on transfer go to APPLY, otherwise stay.
  - APPLY: drive the bank for exactly one cycle, then go to DONE.
  - DONE: done=1 for exactly this one cycle, then go to IDLE.
  - No command is accepted in APPLY or DONE.
- J/K mapping in APPLY (m = latched mask):
  - HOLD: j=0, k=0.
  - SET: j=m, k=0.
  - CLEAR: j=0, k=m.
  - TOGGLE: j=m, k=m.
  - Outside APPLY: j=k=0 and bank enable is low.
- Bank update per bit: q_next = (j & ~q) | (~k & q).
- Timing:
  - Transfer at edge E. APPLY during cycle E..E+1. New q visible and done=1 in the cycle after edge E+1. IDLE again after edge E+2.
  - Throughput: one command per 3 cycles.
- Boundary conditions:
  - HOLD and mask=0 still run the full sequence and still pulse done; q is unchanged.
  - A requester dropping valid without a transfer is a protocol violation; behaviour is undefined.
  - Reset in APPLY or DONE: q=0, no done pulse, latched command discarded.
  - Masked bits are independent; unmasked bits never change.

Optional Feature:
- Macro JK_BANK_FIXED_PRIO_EN.
  - Defined: fixed priority. req0 always wins when both are valid; last_grant is unused for selection (grant_id is still updated).
  - Undefined: round-robin as described above.

Decomposition:
- Package jk_bank_pkg holds:
  - opcode constants OP_HOLD/OP_SET/OP_CLEAR/OP_TOGGLE (2-bit);
  - FSM state encoding ST_IDLE/ST_APPLY/ST_DONE;
  - default width constant 8.
- Sub-module jkff_bank: N JK cells with ports clk, reset (sync active-low), en, j[N], k[N], q[N]. Updates only when en=1.
- The arbiter and FSM live in jk_bank_arbiter.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both valid=1 -> q=8'h00, busy=0, done=0, req0_ready=req1_ready=0.
- Single SET: req0 SET mask=8'h0F from q=8'h00 -> req0_ready for 1 cycle, q=8'h0F together with a 1-cycle done two edges after transfer, grant_id=0, busy high for 2 cycles.
- Contention, round-robin: from q=8'h0F, req0 TOGGLE 8'hFF and req1 CLEAR 8'hF0 held valid continuously -> grants 0,1,0,1; q goes 8'hF0, 8'h00, 8'hFF, 8'h0F; 3 cycles between readies.
- HOLD/zero mask: req1 HOLD 8'hFF, then req1 SET 8'h00, both from q=8'hA5 -> q stays 8'hA5, done pulses both times.
- Mid-operation reset: req0 SET 8'hFF accepted, reset=0 during APPLY -> q=8'h00, no done, IDLE. Next contention is granted to req0.
- With JK_BANK_FIXED_PRIO_EN: both valid continuously -> req0_ready only, grant_id stays 0, req1 is never granted until req0_valid drops.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// Shared constants for the JK bank arbiter: opcodes, FSM states and default width.
package jk_bank_pkg;

    localparam int JK_BANK_WIDTH = 8;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/jkff_bank.sv
// Bank of N independent JK flip-flops; cells update only while en is high.
module jkff_bank #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] j,
    input  logic [N-1:0] k,
    output logic [N-1:0] q
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            logic r_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_q <= 1'b0;
                end else if (en) begin
                    r_q <= (j[gi] & ~r_q) | (~k[gi] & r_q);
                end
            end

            assign q[gi] = r_q;
        end
    endgenerate

endmodule

// File: rtl/jk_bank_arbiter.sv
// Two-requester arbiter driving a shared JK bank, one command per IDLE/APPLY/DONE pass.
// Define JK_BANK_FIXED_PRIO_EN for fixed priority (req0 first) instead of round-robin.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int N = JK_BANK_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_mask,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_mask,
    output logic         req1_ready,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         grant_id,
    output logic         done
);

    state_t       r_state;
    logic [1:0]   r_op;
    logic [N-1:0] r_mask;
    logic         r_grant_id;
    logic         r_busy;
    logic         r_done;

    logic         w_win0;
    logic         w_win1;
    logic         w_take;
    logic         w_xfer;
    logic         w_en;
    logic [N-1:0] w_j;
    logic [N-1:0] w_k;

`ifdef JK_BANK_FIXED_PRIO_EN
    assign w_win0 = req0_valid;
    assign w_win1 = req1_valid && !req0_valid;
`else
    logic r_last_grant;

    // Under contention the requester that did not win last time goes first.
    assign w_win0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_win1 = req1_valid && (!req0_valid || !r_last_grant);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_win1;
        end
    end
`endif

    assign w_take     = reset && (r_state == ST_IDLE);
    assign req0_ready = w_take && w_win0;
    assign req1_ready = w_take && w_win1;
    assign w_xfer     = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_HOLD;
            r_mask     <= '0;
            r_grant_id <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_state    <= ST_APPLY;
                        r_op       <= w_win0 ? req0_op : req1_op;
                        r_mask     <= w_win0 ? req0_mask : req1_mask;
                        r_grant_id <= w_win1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_en = (r_state == ST_APPLY);

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (w_en) begin
            case (r_op)
                OP_SET:    w_j = r_mask;
                OP_CLEAR:  w_k = r_mask;
                OP_TOGGLE: begin
                    w_j = r_mask;
                    w_k = r_mask;
                end
                default: ;
            endcase
        end
    end

    jkff_bank #(
        .N(N)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .en   (w_en),
        .j    (w_j),
        .k    (w_k),
        .q    (q)
    );

    assign busy     = r_busy;
    assign grant_id = r_grant_id;
    assign done     = r_done;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_mask, req1_mask;
    logic       req0_ready, req1_ready;
    logic [7:0] q;
    logic       busy, grant_id, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0 = idle, 1 = bank being written, 2 = result shown.
    logic [7:0] m_q     = 8'h00;
    int         m_phase = 0;
    logic       m_gid   = 1'b0;
    logic       m_last  = 1'b1;
    logic [1:0] m_op    = 2'b00;
    logic [7:0] m_mask  = 8'h00;
    bit         m_started = 1'b0;
    bit         acc0 = 1'b0;
    bit         acc1 = 1'b0;

    logic [7:0] cont_q[4];
    logic       cont_g[4];

    always #5 clk = ~clk;

    jk_bank_arbiter #(.N(8)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req0_valid(req0_valid),
        .req0_op   (req0_op),
        .req0_mask (req0_mask),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_op   (req1_op),
        .req1_mask (req1_mask),
        .req1_ready(req1_ready),
        .q         (q),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int win(input logic v0, input logic v1, input logic lg);
        int w;
        if (v0 && v1) begin
`ifdef JK_BANK_FIXED_PRIO_EN
            w = 0;
`else
            w = lg ? 0 : 1;
`endif
        end else if (v0) w = 0;
        else if (v1) w = 1;
        else w = -1;
        return w;
    endfunction

    always @(posedge clk) begin : model_update
        int w;
        w = win(req0_valid, req1_valid, m_last);
        acc0 <= 1'b0;
        acc1 <= 1'b0;
        if (!rst_n) begin
            m_q       <= 8'h00;
            m_phase   <= 0;
            m_gid     <= 1'b0;
            m_last    <= 1'b1;
            m_started <= 1'b1;
        end else if (m_phase == 0) begin
            if (w >= 0) begin
                m_phase <= 1;
                m_gid   <= (w == 1);
                m_last  <= (w == 1);
                m_op    <= (w == 0) ? req0_op : req1_op;
                m_mask  <= (w == 0) ? req0_mask : req1_mask;
                if (w == 0) acc0 <= 1'b1;
                else        acc1 <= 1'b1;
            end
        end else if (m_phase == 1) begin
            case (m_op)
                2'b01:   m_q <= m_q | m_mask;
                2'b10:   m_q <= m_q & ~m_mask;
                2'b11:   m_q <= m_q ^ m_mask;
                default: m_q <= m_q;
            endcase
            m_phase <= 2;
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin : compare
        int  w;
        logic e0, e1;
        #1;
        if (m_started) begin
            w  = win(req0_valid, req1_valid, m_last);
            e0 = rst_n && (m_phase == 0) && (w == 0);
            e1 = rst_n && (m_phase == 0) && (w == 1);
            chk("q", q, m_q);
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == 2);
            chk("grant_id", grant_id, m_gid);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
        end
    end

    task automatic wait_acc(input int id);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk);
            #1;
            got = (id == 0) ? acc0 : acc1;
        end
        chk("accept_seen", got, 1);
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            #2;
            got = (done === 1'b1);
        end
    endtask

    task automatic issue(input int id, input logic [1:0] op, input logic [7:0] m);
        bit got;
        @(negedge clk);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_mask = m;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_mask = m;
        end
        wait_acc(id);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done(got);
        chk("done_seen", got, 1);
    endtask

    initial begin
        bit got;
`ifdef JK_BANK_FIXED_PRIO_EN
        cont_q = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
        cont_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        cont_q = '{8'hF0, 8'h00, 8'hFF, 8'h0F};
        cont_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_mask = 8'hFF;
        req1_valid = 1'b1; req1_op = 2'b00; req1_mask = 8'hFF;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        issue(0, 2'b01, 8'h0F);
        chk("set_q", q, 8'h0F);
        chk("set_gid", grant_id, 0);
        issue(1, 2'b00, 8'h00);
        chk("hold_zero_q", q, 8'h0F);

        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b11; req0_mask = 8'hFF;
        req1_valid = 1'b1; req1_op = 2'b10; req1_mask = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            wait_done(got);
            chk("cont_done", got, 1);
            chk("cont_q", q, cont_q[i]);
            chk("cont_gid", grant_id, cont_g[i]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        issue(1, 2'b10, 8'hFF);
        issue(1, 2'b01, 8'hA5);
        chk("a5_q", q, 8'hA5);
        issue(1, 2'b00, 8'hFF);
        chk("hold_q", q, 8'hA5);
        issue(1, 2'b01, 8'h00);
        chk("zero_mask_q", q, 8'hA5);

        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b01; req0_mask = 8'hFF;
        wait_acc(0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("midrst_q", q, 8'h00);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        req0_valid = 1'b1; req0_op = 2'b11; req0_mask = 8'h3C;
        req1_valid = 1'b1; req1_op = 2'b01; req1_mask = 8'hC3;
        #1;
        chk("postrst_ready0", req0_ready, 1);
        chk("postrst_ready1", req1_ready, 0);
        wait_acc(0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done(got);
        chk("postrst_done", got, 1);
        chk("postrst_q", q, 8'h3C);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (acc0 || !rst_n || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op    = 2'($urandom_range(0, 3));
                req0_mask  = 8'($urandom);
            end
            if (acc1 || !rst_n || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op    = 2'($urandom_range(0, 3));
                req1_mask  = 8'($urandom);
            end
            rst_n = ($urandom_range(0, 39) != 0);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
